// File: rtl/sram_req_rsp_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Package : sram_adapter_pkg
// Purpose : Shared defaults, byte-enable width helper and request record
//           type for the SRAM request/response adapter.
// Revision: 1.0 - initial release
// ============================================================================
package sram_adapter_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 64;
    localparam int unsigned ADDR_WIDTH_DEF = 8;

    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    typedef struct packed {
        logic                                  we;
        logic [DATA_WIDTH_DEF/8-1:0]           be;
        logic [ADDR_WIDTH_DEF-1:0]             addr;
        logic [DATA_WIDTH_DEF-1:0]             wdata;
    } sram_req_t;

endpackage
`default_nettype wire

// File: rtl/sram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sram_rsp_fifo
// Purpose : Synchronous FIFO with push/pop, occupancy count and head data;
//           pointers wrap at DEPTH so any depth >= 1 is supported.
// Revision: 1.0 - initial release
// ============================================================================
module sram_rsp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [PTR_W-1:0] r_wptr_q, w_wptr_d;
    logic [PTR_W-1:0] r_rptr_q, w_rptr_d;
    logic [CNT_W-1:0] r_cnt_q,  w_cnt_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        w_wptr_d = r_wptr_q;
        w_rptr_d = r_rptr_q;
        w_cnt_d  = r_cnt_q;
        if (push_i) begin
            w_wptr_d = next_ptr(r_wptr_q);
        end
        if (pop_i) begin
            w_rptr_d = next_ptr(r_rptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   w_cnt_d = r_cnt_q + CNT_W'(1);
            2'b01:   w_cnt_d = r_cnt_q - CNT_W'(1);
            default: w_cnt_d = r_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr_q <= '0;
            r_rptr_q <= '0;
            r_cnt_q  <= '0;
        end else begin
            r_wptr_q <= w_wptr_d;
            r_rptr_q <= w_rptr_d;
            r_cnt_q  <= w_cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem_q[r_wptr_q] <= data_i;
        end
    end

    assign data_o  = r_mem_q[r_rptr_q];
    assign count_o = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/sram_req_rsp_adapter.sv
`default_nettype none
// ============================================================================
// Module  : sram_req_rsp_adapter
// Purpose : Valid/ready request channel to single-port byte-enable SRAM, with
//           credit-checked response FIFO and empty-FIFO read-data bypass.
// Revision: 1.0 - initial release
// ============================================================================
module sram_req_rsp_adapter
    import sram_adapter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned RSP_DEPTH  = 2,
    localparam int unsigned BE_WIDTH  = be_width(DATA_WIDTH)
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  ReqValid_SI,
    output logic                  ReqReady_SO,
    input  logic                  ReqWe_SI,
    input  logic [BE_WIDTH-1:0]   ReqBe_DI,
    input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
    input  logic [DATA_WIDTH-1:0] ReqWData_DI,
    output logic                  RspValid_SO,
    input  logic                  RspReady_SI,
    output logic [DATA_WIDTH-1:0] RspRData_DO,
    output logic                  SramCSel_SO,
    output logic                  SramWrEn_SO,
    output logic [BE_WIDTH-1:0]   SramBEn_SO,
    output logic [ADDR_WIDTH-1:0] SramAddr_DO,
    output logic [DATA_WIDTH-1:0] SramWData_DO,
    input  logic [DATA_WIDTH-1:0] SramRData_DI
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic                  r_rd_inflight_q, w_rd_inflight_d;
    logic [CNT_W-1:0]      w_fifo_cnt;
    logic [DATA_WIDTH-1:0] w_fifo_head;
    logic [31:0]           w_occupancy;
    logic                  w_credit_ok;
    logic                  w_fire;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;

    // Credit counts the read already in flight, so its return always has a slot.
    assign w_occupancy  = 32'(w_fifo_cnt) + 32'(r_rd_inflight_q);
    assign w_credit_ok  = (w_occupancy < RSP_DEPTH);
    assign ReqReady_SO  = w_credit_ok & ~Rst_RI;
    assign w_fire       = ReqValid_SI & ReqReady_SO;

    assign SramCSel_SO  = w_fire;
    assign SramWrEn_SO  = w_fire & ReqWe_SI;
    assign SramBEn_SO   = ReqBe_DI;
    assign SramAddr_DO  = ReqAddr_DI;
    assign SramWData_DO = ReqWData_DI;

    assign w_rd_inflight_d = w_fire & ~ReqWe_SI;

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_rd_inflight_q <= 1'b0;
        end else begin
            r_rd_inflight_q <= w_rd_inflight_d;
        end
    end

    assign w_fifo_empty = (w_fifo_cnt == '0);
    assign RspValid_SO  = (r_rd_inflight_q | ~w_fifo_empty) & ~Rst_RI;
    assign RspRData_DO  = w_fifo_empty ? SramRData_DI : w_fifo_head;

    // Returning data skips the FIFO only when it is empty and the consumer takes it now.
    assign w_push = r_rd_inflight_q & ~(w_fifo_empty & RspReady_SI) & ~Rst_RI;
    assign w_pop  = ~w_fifo_empty & RspReady_SI & ~Rst_RI;

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk_i   (Clk_CI),
        .rst_i   (Rst_RI),
        .push_i  (w_push),
        .data_i  (SramRData_DI),
        .pop_i   (w_pop),
        .data_o  (w_fifo_head),
        .count_o (w_fifo_cnt)
    );

    a_no_overflow: assert property (@(posedge Clk_CI) disable iff (Rst_RI)
        (32'(w_fifo_cnt) <= RSP_DEPTH));

endmodule
`default_nettype wire
